passcode_controller: RTL and testbench

- Keypad-side sequencer for the door-lock state manager.
- Collects digit keys into an entry buffer and compares the buffer against a stored passcode.
- Drives the manager's is_star_pressed, correct and initialize inputs as single-cycle pulses.
- Handles passcode re-programming in the reset state and the timed lockout in the lock state.

---
 rtl/passcode_controller.sv | 205 ++++++++++++++++++++
 tb/tb_passcode_controller.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/passcode_controller.sv
// rtl/passcode_controller.sv - keypad sequencer for the door-lock state manager
//
// Collects BCD digit keys into an entry buffer, checks the entry against a
// stored passcode on star, re-programs the passcode in the manager's reset
// state and runs the timed lockout in the manager's lock state.
//
// Optional feature macro: AUTO_TIMEOUT_EN
//   defined   - an inactivity counter abandons a partial entry after
//               TIMEOUT_CYCLES cycles without a key
//   undefined - no inactivity counter; a partial entry persists
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   synchronous active-low reset
//   key_valid      in   one-cycle strobe qualifying key_code
//   key_code[3:0]  in   0-9 digit, 10 star (submit), 11 hash (clear), 12-15 ignored
//   lock_state[2:0] in  manager state: 000 off, 001 on, 010 wrong1, 011 wrong2,
//                       100 answer, 101 reset, 111 lock
//   star_pulse     out  one-cycle pulse to manager is_star_pressed
//   correct        out  one-cycle pulse to manager correct
//   initialize     out  one-cycle pulse to manager initialize
//   entry_count[3:0] out digits currently buffered, saturates at PW_LEN
//   lockout_active out  high while the lockout timer runs
//   pw_updated     out  one-cycle pulse when a new passcode is stored

module passcode_controller #(
    parameter int          PW_LEN         = 4,
    parameter logic [31:0] DEFAULT_PW     = 32'h0000_1234,
    parameter int          LOCK_CYCLES    = 1000,
    parameter int          TIMEOUT_CYCLES = 500
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [2:0] lock_state,
    output logic       star_pulse,
    output logic       correct,
    output logic       initialize,
    output logic [3:0] entry_count,
    output logic       lockout_active,
    output logic       pw_updated
);

    localparam int BW = PW_LEN * 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_PROGRAM,
        S_LOCKOUT
    } state_t;

    state_t        state;
    logic [BW-1:0] buffer;
    logic [BW-1:0] stored;
    logic [3:0]    count;
    logic          overflow;
    logic [31:0]   lock_timer;

    logic is_digit;
    logic is_star;
    logic is_hash;
    logic entry_ok;
    logic full;
    logic leave_entry;

    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_star  = key_valid && (key_code == 4'd10);
    assign is_hash  = key_valid && (key_code == 4'd11);
    assign entry_ok = (lock_state == 3'b001) || (lock_state == 3'b010) ||
                      (lock_state == 3'b011);
    assign full     = (count == 4'(PW_LEN));
    // COLLECT is only valid in the on/wrong states, PROGRAM only in reset.
    assign leave_entry = (state == S_PROGRAM) ? (lock_state != 3'b101) : !entry_ok;

    assign entry_count = count;

`ifdef AUTO_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        idle_expired;
    assign idle_expired = !key_valid && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            buffer         <= '0;
            stored         <= DEFAULT_PW[BW-1:0];
            count          <= '0;
            overflow       <= 1'b0;
            lock_timer     <= '0;
            star_pulse     <= 1'b0;
            correct        <= 1'b0;
            initialize     <= 1'b0;
            lockout_active <= 1'b0;
            pw_updated     <= 1'b0;
`ifdef AUTO_TIMEOUT_EN
            idle_cnt       <= '0;
`endif
        end else begin
            // Pulses are asserted for exactly one cycle by the branches below.
            star_pulse <= 1'b0;
            correct    <= 1'b0;
            initialize <= 1'b0;
            pw_updated <= 1'b0;

            case (state)
                S_IDLE: begin
`ifdef AUTO_TIMEOUT_EN
                    idle_cnt <= '0;
`endif
                    if (lock_state == 3'b111) begin
                        state          <= S_LOCKOUT;
                        lock_timer     <= 32'(LOCK_CYCLES - 1);
                        lockout_active <= 1'b1;
                    end else if (lock_state == 3'b101) begin
                        state <= S_PROGRAM;
                    end else if (entry_ok && is_digit) begin
                        buffer <= {buffer[BW-5:0], key_code};
                        count  <= 4'd1;
                        state  <= S_COLLECT;
                    end
                end

                S_COLLECT, S_PROGRAM: begin
`ifdef AUTO_TIMEOUT_EN
                    idle_cnt <= key_valid ? 32'd0 : idle_cnt + 32'd1;
`endif
                    if (leave_entry) begin
                        buffer   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= S_IDLE;
                    end else if (is_digit) begin
                        if (!full) begin
                            buffer <= {buffer[BW-5:0], key_code};
                            count  <= count + 4'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end else if (is_hash) begin
                        buffer   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        if (state == S_COLLECT) begin
                            state <= S_IDLE;
                        end
                    end else if (is_star) begin
                        if (state == S_COLLECT) begin
                            // Entry is kept intact for the comparison in CHECK.
                            state <= S_CHECK;
                        end else begin
                            if (full && !overflow) begin
                                stored     <= buffer;
                                pw_updated <= 1'b1;
                                initialize <= 1'b1;
                            end
                            buffer   <= '0;
                            count    <= '0;
                            overflow <= 1'b0;
                            state    <= S_IDLE;
                        end
`ifdef AUTO_TIMEOUT_EN
                    end else if (idle_expired) begin
                        buffer   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        state    <= S_IDLE;
`endif
                    end
                end

                S_CHECK: begin
                    star_pulse <= 1'b1;
                    correct    <= full && !overflow && (buffer == stored);
                    buffer     <= '0;
                    count      <= '0;
                    overflow   <= 1'b0;
                    state      <= S_IDLE;
                end

                S_LOCKOUT: begin
                    if (lock_state != 3'b111) begin
                        lockout_active <= 1'b0;
                        state          <= S_IDLE;
                    end else if (lock_timer == 32'd0) begin
                        initialize     <= 1'b1;
                        lockout_active <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        lock_timer <= lock_timer - 32'd1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_passcode_controller.sv
// tb/tb_passcode_controller.sv - directed self-checking bench for passcode_controller

module tb_passcode_controller;

    logic       clk;
    logic       reset_n;
    logic       key_valid;
    logic [3:0] key_code;
    logic [2:0] lock_state;
    logic       star_pulse;
    logic       correct;
    logic       initialize;
    logic [3:0] entry_count;
    logic       lockout_active;
    logic       pw_updated;

    int vectors;
    int miscompares;

    passcode_controller #(
        .PW_LEN        (4),
        .DEFAULT_PW    (32'h0000_1234),
        .LOCK_CYCLES   (10),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .lock_state    (lock_state),
        .star_pulse    (star_pulse),
        .correct       (correct),
        .initialize    (initialize),
        .entry_count   (entry_count),
        .lockout_active(lockout_active),
        .pw_updated    (pw_updated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        tick();
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic press_four(input logic [3:0] a, b, c, d);
        press(a);
        press(b);
        press(c);
        press(d);
    endtask

    // Presses star and samples: right after the star edge, one edge later
    // (pulse cycle) and two edges later (pulses gone).
    task automatic submit(output logic early, output logic sp, output logic cr,
                          output logic [3:0] cnt, output logic late);
        press(4'd10);
        early = star_pulse | correct;
        tick();
        sp  = star_pulse;
        cr  = correct;
        cnt = entry_count;
        tick();
        late = star_pulse | correct;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        lock_state = 3'b000;
        tick();
        tick();
        vectors++;
        if ({star_pulse, correct, initialize, lockout_active, pw_updated, entry_count} !== 9'd0) begin
            $display("FAIL reset_outputs got %b want 000000000",
                     {star_pulse, correct, initialize, lockout_active, pw_updated, entry_count});
            miscompares++;
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_correct_entry();
        logic e, sp, cr, l;
        logic [3:0] cnt;
        lock_state = 3'b001;
        press_four(4'd1, 4'd2, 4'd3, 4'd4);
        vectors++;
        if (entry_count !== 4'd4) begin
            $display("FAIL correct_count got %0d want 4", entry_count);
            miscompares++;
        end
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({e, sp, cr, l} !== 4'b0110 || cnt !== 4'd0) begin
            $display("FAIL correct_submit got early=%b sp=%b cr=%b late=%b cnt=%0d want 0 1 1 0 0",
                     e, sp, cr, l, cnt);
            miscompares++;
        end
    endtask

    task automatic test_wrong_entry();
        logic e, sp, cr, l;
        logic [3:0] cnt;
        lock_state = 3'b010;
        press(4'd1);
        press(4'd2);
        press(4'd13);
        vectors++;
        if (entry_count !== 4'd2) begin
            $display("FAIL ignored_key_count got %0d want 2", entry_count);
            miscompares++;
        end
        press(4'd3);
        press(4'd5);
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({e, sp, cr, l} !== 4'b0100) begin
            $display("FAIL wrong_submit got early=%b sp=%b cr=%b late=%b want 0 1 0 0", e, sp, cr, l);
            miscompares++;
        end
        press_four(4'd1, 4'd2, 4'd3, 4'd4);
        press(4'd5);
        vectors++;
        if (entry_count !== 4'd4) begin
            $display("FAIL overflow_saturate got %0d want 4", entry_count);
            miscompares++;
        end
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({sp, cr} !== 2'b10) begin
            $display("FAIL overflow_submit got sp=%b cr=%b want 1 0", sp, cr);
            miscompares++;
        end
        // Too short an entry is rejected.
        press(4'd1);
        press(4'd2);
        press(4'd3);
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({sp, cr} !== 2'b10) begin
            $display("FAIL short_submit got sp=%b cr=%b want 1 0", sp, cr);
            miscompares++;
        end
    endtask

    task automatic test_hash_and_leave();
        logic e, sp, cr, l;
        logic [3:0] cnt;
        lock_state = 3'b001;
        press(4'd9);
        press(4'd9);
        press(4'd11);
        vectors++;
        if (entry_count !== 4'd0) begin
            $display("FAIL hash_clear got %0d want 0", entry_count);
            miscompares++;
        end
        press(4'd7);
        lock_state = 3'b000;
        tick();
        vectors++;
        if (entry_count !== 4'd0) begin
            $display("FAIL leave_clear got %0d want 0", entry_count);
            miscompares++;
        end
        press(4'd4);
        vectors++;
        if (entry_count !== 4'd0) begin
            $display("FAIL off_state_digit got %0d want 0", entry_count);
            miscompares++;
        end
        // Held key_valid counts as one key per cycle.
        lock_state = 3'b001;
        key_valid = 1'b1;
        key_code = 4'd1;
        tick();
        tick();
        key_code = 4'd2;
        tick();
        key_valid = 1'b0;
        vectors++;
        if (entry_count !== 4'd3) begin
            $display("FAIL held_key_count got %0d want 3", entry_count);
            miscompares++;
        end
        press(4'd11);
        press_four(4'd1, 4'd2, 4'd3, 4'd4);
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({sp, cr} !== 2'b11) begin
            $display("FAIL after_hash_submit got sp=%b cr=%b want 1 1", sp, cr);
            miscompares++;
        end
    endtask

    task automatic test_program();
        logic e, sp, cr, l;
        logic [3:0] cnt;
        lock_state = 3'b101;
        tick();
        press_four(4'd9, 4'd8, 4'd7, 4'd6);
        press(4'd10);
        vectors++;
        if ({pw_updated, initialize, star_pulse, correct} !== 4'b1100) begin
            $display("FAIL program_pulse got upd=%b init=%b sp=%b cr=%b want 1 1 0 0",
                     pw_updated, initialize, star_pulse, correct);
            miscompares++;
        end
        lock_state = 3'b001;
        tick();
        vectors++;
        if ({pw_updated, initialize} !== 2'b00) begin
            $display("FAIL program_pulse_len got upd=%b init=%b want 0 0", pw_updated, initialize);
            miscompares++;
        end
        press_four(4'd9, 4'd8, 4'd7, 4'd6);
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({sp, cr} !== 2'b11) begin
            $display("FAIL new_pw_submit got sp=%b cr=%b want 1 1", sp, cr);
            miscompares++;
        end
        press_four(4'd1, 4'd2, 4'd3, 4'd4);
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({sp, cr} !== 2'b10) begin
            $display("FAIL old_pw_submit got sp=%b cr=%b want 1 0", sp, cr);
            miscompares++;
        end
        // Short programming entry is discarded with no pulses.
        lock_state = 3'b101;
        tick();
        press(4'd5);
        press(4'd5);
        press(4'd10);
        vectors++;
        if ({pw_updated, initialize} !== 2'b00) begin
            $display("FAIL short_program got upd=%b init=%b want 0 0", pw_updated, initialize);
            miscompares++;
        end
        lock_state = 3'b001;
        tick();
        press_four(4'd9, 4'd8, 4'd7, 4'd6);
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({sp, cr} !== 2'b11) begin
            $display("FAIL pw_kept_submit got sp=%b cr=%b want 1 1", sp, cr);
            miscompares++;
        end
    endtask

    task automatic test_lockout();
        int high_cycles;
        lock_state = 3'b111;
        tick();
        high_cycles = 0;
        if (lockout_active === 1'b1) high_cycles++;
        for (int i = 0; i < 9; i++) begin
            key_valid = 1'b1;
            key_code = 4'(i);
            tick();
            if (lockout_active === 1'b1 && initialize === 1'b0 && entry_count === 4'd0)
                high_cycles++;
        end
        key_valid = 1'b0;
        vectors++;
        if (high_cycles !== 10) begin
            $display("FAIL lockout_active_cycles got %0d want 10", high_cycles);
            miscompares++;
        end
        tick();
        vectors++;
        if ({lockout_active, initialize} !== 2'b01) begin
            $display("FAIL lockout_end got act=%b init=%b want 0 1", lockout_active, initialize);
            miscompares++;
        end
        lock_state = 3'b000;
        tick();
        vectors++;
        if (initialize !== 1'b0) begin
            $display("FAIL lockout_init_len got %b want 0", initialize);
            miscompares++;
        end
        // Early abort: no initialize.
        lock_state = 3'b111;
        tick();
        tick();
        lock_state = 3'b000;
        tick();
        tick();
        vectors++;
        if ({lockout_active, initialize} !== 2'b00) begin
            $display("FAIL lockout_abort got act=%b init=%b want 0 0", lockout_active, initialize);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_entry();
        logic e, sp, cr, l;
        logic [3:0] cnt;
        lock_state = 3'b001;
        press(4'd1);
        press(4'd2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        vectors++;
        if ({entry_count, star_pulse, correct, initialize, pw_updated} !== 8'd0) begin
            $display("FAIL reset_mid_entry got %b want 00000000",
                     {entry_count, star_pulse, correct, initialize, pw_updated});
            miscompares++;
        end
        press_four(4'd1, 4'd2, 4'd3, 4'd4);
        submit(e, sp, cr, cnt, l);
        vectors++;
        if ({sp, cr} !== 2'b11) begin
            $display("FAIL default_pw_restored got sp=%b cr=%b want 1 1", sp, cr);
            miscompares++;
        end
    endtask

    task automatic test_timeout();
        logic saw_star;
        logic [3:0] want_end;
`ifdef AUTO_TIMEOUT_EN
        want_end = 4'd0;
`else
        want_end = 4'd1;
`endif
        lock_state = 3'b001;
        press(4'd1);
        saw_star = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            saw_star |= star_pulse;
        end
        vectors++;
        if (entry_count !== 4'd1) begin
            $display("FAIL timeout_before got %0d want 1", entry_count);
            miscompares++;
        end
        tick();
        saw_star |= star_pulse;
        vectors++;
        if (entry_count !== want_end || saw_star !== 1'b0) begin
            $display("FAIL timeout_after got cnt=%0d sp=%b want cnt=%0d sp=0",
                     entry_count, saw_star, want_end);
            miscompares++;
        end
        press(4'd11);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_correct_entry();
        test_wrong_entry();
        test_hash_and_leave();
        test_program();
        test_lockout();
        test_reset_mid_entry();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
